// File: rtl/prefix8_serial_pkg.sv
// Shared constants and the registered result record for the byte-serial adder.
// Used by prefix8_serial_add and prefix8_cin_core.
package prefix8_serial_pkg;

  localparam int BYTE_W        = 8;
  localparam int MAX_BYTES_DEF = 4;

  typedef struct packed {
    logic [BYTE_W-1:0] sum;
    logic              last;
    logic              cout;
  } out_rec_t;

endpackage

// File: rtl/prefix8_cin_core.sv
// Combinational 8-bit Kogge-Stone adder with carry-in.
// The carry-in is folded into bit 0's generate term, so the prefix tree yields every carry directly.
module prefix8_cin_core
  import prefix8_serial_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] g0;
  logic [BYTE_W-1:0] p0;
  logic [BYTE_W-1:0] gt [0:3];
  logic [BYTE_W-1:0] pt [0:3];
  logic [BYTE_W-1:0] carry;

  always_comb begin
    g0 = a & b;
    p0 = a ^ b;
    gt[0] = g0;
    gt[0][0] = g0[0] | (p0[0] & cin);
    pt[0] = p0;
    for (int k = 0; k < 3; k++) begin
      gt[k+1] = gt[k];
      pt[k+1] = pt[k];
      for (int i = 0; i < BYTE_W; i++) begin
        if (i >= (1 << k)) begin
          gt[k+1][i] = gt[k][i] | (pt[k][i] & gt[k][i-(1<<k)]);
          pt[k+1][i] = pt[k][i] & pt[k][i-(1<<k)];
        end
      end
    end
    carry = {gt[3][BYTE_W-2:0], cin};
    sum   = p0 ^ carry;
    cout  = gt[3][BYTE_W-1];
  end

endmodule

// File: rtl/prefix8_serial_add.sv
// Byte-serial multi-precision adder stage with valid/ready handshake and registered output.
// Build option PREFIX8_SERIAL_SUB_EN adds in_sub for per-word A-B subtraction.
module prefix8_serial_add
  import prefix8_serial_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_last,
`ifdef PREFIX8_SERIAL_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt
);

  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q;
  logic              busy_q;
  logic              out_valid_q;
  out_rec_t          out_q;
  out_rec_t          out_d;

  logic              in_fire;
  logic              first;
  logic              eff_last;
  logic              cin;
  logic [BYTE_W-1:0] b_op;
  logic [BYTE_W-1:0] sum;
  logic              cout;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign first    = (cnt_q == '0);
  assign eff_last = in_last || (cnt_q == CNT_W'(MAX_BYTES - 1));

`ifdef PREFIX8_SERIAL_SUB_EN
  logic sub_q;
  logic eff_sub;

  // Mode is taken live on the first byte and from the register afterwards.
  assign eff_sub = first ? in_sub : sub_q;
  assign b_op    = eff_sub ? ~in_b : in_b;
  assign cin     = first ? eff_sub : carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (in_fire && first) begin
      sub_q <= in_sub;
    end
  end
`else
  assign b_op = in_b;
  assign cin  = first ? 1'b0 : carry_q;
`endif

  prefix8_cin_core u_core (
    .a    (in_a),
    .b    (b_op),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    out_d      = '0;
    out_d.sum  = sum;
    out_d.last = eff_last;
    out_d.cout = eff_last & cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (in_fire) begin
      out_q       <= out_d;
      out_valid_q <= 1'b1;
      if (eff_last) begin
        carry_q <= 1'b0;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        carry_q <= cout;
        cnt_q   <= cnt_q + CNT_W'(1);
        busy_q  <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_q.sum;
  assign out_last  = out_q.last;
  assign out_cout  = out_q.cout;
  assign busy      = busy_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_prefix8_serial_add.sv
// Self-checking bench for prefix8_serial_add (default build, addition only).
module tb_prefix8_serial_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_sum;
  logic       out_last;
  logic       out_cout;
  logic       busy;
  logic [2:0] byte_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] s;
    logic       l;
    logic       c;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  prefix8_serial_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  // Collect every result byte that will be consumed at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      rec_t r;
      r.s = out_sum;
      r.l = out_last;
      r.c = out_cout;
      got_q.push_back(r);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present a byte pair and wait for it to be accepted; leaves in_valid high.
  task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: in_ready=%0b after 200 cycles, required 1", in_ready);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_last, out_cout, busy, byte_cnt, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: valid=%0b sum=%h last=%0b cout=%0b busy=%0b cnt=%0d rdy=%0b, required 0 00 0 0 0 0 1",
               out_valid, out_sum, out_last, out_cout, busy, byte_cnt, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_overflow();
    send_byte(8'hFF, 8'h01, 1'b1);
    idle();
    n_cmp++;
    if ({out_valid, out_sum, out_last, out_cout} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL single_overflow: valid=%0b sum=%h last=%0b cout=%0b, required 1 00 1 1", out_valid, out_sum, out_last, out_cout);
    end
    n_cmp++;
    if ({busy, byte_cnt} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL single_busy: busy=%0b cnt=%0d, required 0 0", busy, byte_cnt);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_carry_chain();
    send_byte(8'hFF, 8'h01, 1'b0);
    n_cmp++;
    if ({out_sum, out_last, out_cout, busy, byte_cnt} !== {8'h00, 1'b0, 1'b0, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL chain_b0: sum=%h last=%0b cout=%0b busy=%0b cnt=%0d, required 00 0 0 1 1", out_sum, out_last, out_cout, busy, byte_cnt);
    end
    send_byte(8'h01, 8'h00, 1'b1);
    idle();
    n_cmp++;
    if ({out_sum, out_last, out_cout, busy, byte_cnt} !== {8'h02, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL chain_b1: sum=%h last=%0b cout=%0b busy=%0b cnt=%0d, required 02 1 0 0 0", out_sum, out_last, out_cout, busy, byte_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_byte(8'h10, 8'h20, 1'b0);
    in_a = 8'h01;
    in_b = 8'h02;
    in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = 8'h01 + 8'(i);
      n_cmp++;
      if ({in_ready, out_valid, out_sum} !== {1'b0, 1'b1, 8'h30}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: rdy=%0b valid=%0b sum=%h, required 0 1 30", i, in_ready, out_valid, out_sum);
      end
    end
    in_a = 8'h01;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_last} !== {1'b1, 8'h03, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_release: valid=%0b sum=%h last=%0b, required 1 03 0", out_valid, out_sum, out_last);
    end
    in_a = 8'h05;
    in_b = 8'h06;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    idle();
    n_cmp++;
    if ({out_valid, out_sum, out_last, out_cout, byte_cnt} !== {1'b1, 8'h0B, 1'b1, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL back_to_back: valid=%0b sum=%h last=%0b cout=%0b cnt=%0d, required 1 0b 1 0 0",
               out_valid, out_sum, out_last, out_cout, byte_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_auto_last();
    logic [7:0] exp_s [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFF, (i == 0) ? 8'h01 : 8'h00, 1'b0);
      n_cmp++;
      if ({out_sum, out_last, out_cout} !== {exp_s[i], (i == 3), (i == 3)}) begin
        n_bad++;
        $display("FAIL auto_last[%0d]: sum=%h last=%0b cout=%0b, required %h %0b %0b",
                 i, out_sum, out_last, out_cout, exp_s[i], (i == 3), (i == 3));
      end
    end
    n_cmp++;
    if ({busy, byte_cnt} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL auto_last_cnt: busy=%0b cnt=%0d, required 0 0", busy, byte_cnt);
    end
    send_byte(8'h01, 8'h01, 1'b1);
    idle();
    n_cmp++;
    if ({out_sum, out_last, out_cout} !== {8'h02, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL auto_last_next: sum=%h last=%0b cout=%0b, required 02 1 0", out_sum, out_last, out_cout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h80, 8'h80, 1'b0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, byte_cnt, busy} !== {1'b0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: valid=%0b cnt=%0d busy=%0b, required 0 0 0", out_valid, byte_cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h01, 8'h01, 1'b1);
    idle();
    n_cmp++;
    if ({out_sum, out_last, out_cout} !== {8'h02, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_fresh: sum=%h last=%0b cout=%0b, required 02 1 0", out_sum, out_last, out_cout);
    end
    @(posedge clk);
    #1;
  endtask

  // Random words checked against whole-word integer addition.
  task automatic test_random_words();
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    rand_ready = 1'b1;
    for (int w = 0; w < 40; w++) begin
      int n;
      logic [32:0] wa;
      logic [32:0] wb;
      logic [32:0] ws;
      n  = $urandom_range(1, 4);
      wa = '0;
      wb = '0;
      for (int i = 0; i < n; i++) begin
        wa[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        wb[8*i +: 8] = 8'($urandom);
      end
      ws = wa + wb;
      for (int i = 0; i < n; i++) begin
        rec_t r;
        r.s = ws[8*i +: 8];
        r.l = (i == n - 1);
        r.c = (i == n - 1) ? ws[8*n] : 1'b0;
        exp_q.push_back(r);
      end
      for (int i = 0; i < n; i++) begin
        logic lst;
        lst = (i == n - 1) && !(n == 4 && $urandom_range(0, 1) == 0);
        send_byte(wa[8*i +: 8], wb[8*i +: 8], lst);
        if ($urandom_range(0, 4) == 0) begin
          idle();
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && got_q.size() < exp_q.size(); t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if ({got_q[i].s, got_q[i].l, got_q[i].c} !== {exp_q[i].s, exp_q[i].l, exp_q[i].c}) begin
        n_bad++;
        $display("FAIL rand_byte[%0d]: sum=%h last=%0b cout=%0b, required %h %0b %0b",
                 i, got_q[i].s, got_q[i].l, got_q[i].c, exp_q[i].s, exp_q[i].l, exp_q[i].c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_overflow();
    test_carry_chain();
    test_backpressure();
    test_auto_last();
    test_reset_mid_word();
    test_random_words();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
